// File: rtl/lcd_pkg.sv
// Shared types and constants for the HD44780 character LCD write controller.
package lcd_pkg;

    typedef enum logic [2:0] {
        ST_PWRUP     = 3'd0,
        ST_INIT_LOAD = 3'd1,
        ST_IDLE      = 3'd2,
        ST_SETUP     = 3'd3,
        ST_EN_HIGH   = 3'd4,
        ST_HOLD      = 3'd5,
        ST_WAIT      = 3'd6
    } lcd_state_e;

    // Power-up init sequence, sent in this order.
    localparam logic [7:0] LCD_FUNC_SET = 8'h38;
    localparam logic [7:0] LCD_DISP_ON  = 8'h0C;
    localparam logic [7:0] LCD_CLEAR    = 8'h01;
    localparam logic [7:0] LCD_ENTRY    = 8'h06;
    localparam logic [7:0] LCD_HOME     = 8'h02;
    localparam int         INIT_LEN     = 4;

    // Clear and return-home (0x02 and its don't-care twin 0x03) are the slow
    // instructions; they only apply to the instruction register (rs=0).
    function automatic logic needs_long_wait(input logic rs, input logic [7:0] data);
        return (rs == 1'b0) &&
               ((data == LCD_CLEAR) || (data == LCD_HOME) || (data == 8'h03));
    endfunction

endpackage

// File: rtl/lcd_delay_cnt.sv
// Loadable down-counter used to time every phase of the LCD bus cycle.
// Stops at zero; never wraps.
module lcd_delay_cnt
    import lcd_pkg::*;
#(
    parameter int               CNT_W   = 20,
    parameter logic [CNT_W-1:0] RST_VAL = '0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             cnt_zero
);

    logic [CNT_W-1:0] cnt_r;

    // Load on phase entry, otherwise count down and hold at zero.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_r <= RST_VAL;
        end else if (load) begin
            cnt_r <= load_val;
        end else if (cnt_r != {CNT_W{1'b0}}) begin
            cnt_r <= cnt_r - CNT_W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign cnt_zero = (cnt_r == {CNT_W{1'b0}});

endmodule

// File: rtl/lcd_ctrl.sv
// HD44780 write-only controller: power-up init, then one timed bus cycle
// (setup / enable / hold / execution wait) per accepted byte.
module lcd_ctrl
    import lcd_pkg::*;
#(
    parameter int T_PWRUP = 750000,
    parameter int T_SETUP = 4,
    parameter int T_EN    = 25,
    parameter int T_HOLD  = 2,
    parameter int T_CMD   = 2500,
    parameter int T_CLR   = 100000,
    parameter int CNT_W   = 20
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       wr_valid,
    output logic       wr_ready,
    input  logic       wr_rs,
    input  logic [7:0] wr_data,
    output logic       init_done,
    output logic       lcd_on,
    output logic       lcd_en,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic [7:0] lcd_data
);

    localparam logic [CNT_W-1:0] PWRUP_LD = CNT_W'(T_PWRUP - 1);
    localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(T_SETUP - 1);
    localparam logic [CNT_W-1:0] EN_LD    = CNT_W'(T_EN - 1);
    localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(T_HOLD - 1);
    localparam logic [CNT_W-1:0] CMD_LD   = CNT_W'(T_CMD - 1);
    localparam logic [CNT_W-1:0] CLR_LD   = CNT_W'(T_CLR - 1);
    localparam logic [1:0]       INIT_LAST = 2'(INIT_LEN - 1);

    lcd_state_e       state_r;
    logic             wr_ready_r;
    logic             init_done_r;
    logic             lcd_on_r;
    logic             lcd_en_r;
    logic             lcd_rs_r;
    logic [7:0]       lcd_data_r;
    logic [1:0]       init_idx_r;

    logic             accept_s;
    logic             cnt_load_s;
    logic [CNT_W-1:0] cnt_val_s;
    logic             cnt_zero_s;
    logic [7:0]       rom_data_s;

    assign accept_s = wr_valid && wr_ready_r;

    lcd_delay_cnt #(
        .CNT_W   (CNT_W),
        .RST_VAL (PWRUP_LD)
    ) u_delay (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .load     (cnt_load_s),
        .load_val (cnt_val_s),
        .cnt_zero (cnt_zero_s)
    );

    // Init ROM: command sent for each step of the power-up sequence.
    always_comb begin
        rom_data_s = LCD_FUNC_SET;
        case (init_idx_r)
            2'd0:    rom_data_s = LCD_FUNC_SET;
            2'd1:    rom_data_s = LCD_DISP_ON;
            2'd2:    rom_data_s = LCD_CLEAR;
            2'd3:    rom_data_s = LCD_ENTRY;
            default: rom_data_s = LCD_FUNC_SET;
        endcase
    end

    // Counter reload: each timed phase starts at N-1 on the edge that enters it.
    always_comb begin
        cnt_load_s = 1'b0;
        cnt_val_s  = SETUP_LD;
        case (state_r)
            ST_INIT_LOAD: begin
                cnt_load_s = 1'b1;
                cnt_val_s  = SETUP_LD;
            end
            ST_IDLE: begin
                if (accept_s) begin
                    cnt_load_s = 1'b1;
                    cnt_val_s  = SETUP_LD;
                end else begin
                    cnt_load_s = 1'b0;
                end
            end
            ST_SETUP: begin
                if (cnt_zero_s) begin
                    cnt_load_s = 1'b1;
                    cnt_val_s  = EN_LD;
                end else begin
                    cnt_load_s = 1'b0;
                end
            end
            ST_EN_HIGH: begin
                if (cnt_zero_s) begin
                    cnt_load_s = 1'b1;
                    cnt_val_s  = HOLD_LD;
                end else begin
                    cnt_load_s = 1'b0;
                end
            end
            ST_HOLD: begin
                if (cnt_zero_s) begin
                    cnt_load_s = 1'b1;
                    cnt_val_s  = needs_long_wait(lcd_rs_r, lcd_data_r) ? CLR_LD : CMD_LD;
                end else begin
                    cnt_load_s = 1'b0;
                end
            end
            default: begin
                cnt_load_s = 1'b0;
                cnt_val_s  = SETUP_LD;
            end
        endcase
    end

    // Sequencer: walks init ROM, then services one handshake write per bus cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r     <= ST_PWRUP;
            wr_ready_r  <= 1'b0;
            init_done_r <= 1'b0;
            lcd_on_r    <= 1'b0;
            lcd_en_r    <= 1'b0;
            lcd_rs_r    <= 1'b0;
            lcd_data_r  <= 8'h00;
            init_idx_r  <= 2'd0;
        end else begin
            lcd_on_r <= 1'b1;
            case (state_r)
                ST_PWRUP: begin
                    if (cnt_zero_s) begin
                        state_r <= ST_INIT_LOAD;
                    end
                end
                ST_INIT_LOAD: begin
                    lcd_rs_r   <= 1'b0;
                    lcd_data_r <= rom_data_s;
                    state_r    <= ST_SETUP;
                end
                ST_IDLE: begin
                    if (accept_s) begin
                        lcd_rs_r   <= wr_rs;
                        lcd_data_r <= wr_data;
                        wr_ready_r <= 1'b0;
                        state_r    <= ST_SETUP;
                    end else begin
                        wr_ready_r <= init_done_r;
                    end
                end
                ST_SETUP: begin
                    if (cnt_zero_s) begin
                        lcd_en_r <= 1'b1;
                        state_r  <= ST_EN_HIGH;
                    end
                end
                ST_EN_HIGH: begin
                    if (cnt_zero_s) begin
                        lcd_en_r <= 1'b0;
                        state_r  <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (cnt_zero_s) begin
                        state_r <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (cnt_zero_s) begin
                        if (!init_done_r) begin
                            if (init_idx_r == INIT_LAST) begin
                                init_done_r <= 1'b1;
                                state_r     <= ST_IDLE;
                            end else begin
                                init_idx_r <= init_idx_r + 2'd1;
                                state_r    <= ST_INIT_LOAD;
                            end
                        end else begin
                            state_r <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    state_r <= ST_PWRUP;
                end
            endcase
        end
    end

    assign wr_ready  = wr_ready_r;
    assign init_done = init_done_r;
    assign lcd_on    = lcd_on_r;
    assign lcd_en    = lcd_en_r;
    assign lcd_rs    = lcd_rs_r;
    assign lcd_rw    = 1'b0;
    assign lcd_data  = lcd_data_r;

endmodule

// File: tb/tb_lcd_ctrl.sv
// Scoreboard bench for lcd_ctrl: stimulus queues the expected EN pulses and
// wr_ready return times, an independent monitor checks them as they appear.
module tb_lcd_ctrl;

    localparam int T_PWRUP = 10;
    localparam int T_SETUP = 2;
    localparam int T_EN    = 3;
    localparam int T_HOLD  = 1;
    localparam int T_CMD   = 5;
    localparam int T_CLR   = 20;

    typedef struct {
        logic       rs;
        logic [7:0] data;
        int         tw;
        int         idx;   // init step, or -1 for a host write
        int         acc;   // accepting edge of a host write
    } pulse_t;

    logic       clk = 1'b0;
    logic       rst_ni;
    logic       wr_valid;
    logic       wr_ready;
    logic       wr_rs;
    logic [7:0] wr_data;
    logic       init_done;
    logic       lcd_on;
    logic       lcd_en;
    logic       lcd_rs;
    logic       lcd_rw;
    logic [7:0] lcd_data;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    int rel_cyc = 0;

    pulse_t pulse_q[$];
    int     ready_q[$];
    logic [7:0] init_seq [4] = '{8'h38, 8'h0C, 8'h01, 8'h06};

    lcd_ctrl #(
        .T_PWRUP (T_PWRUP), .T_SETUP (T_SETUP), .T_EN (T_EN),
        .T_HOLD  (T_HOLD),  .T_CMD   (T_CMD),   .T_CLR (T_CLR), .CNT_W (20)
    ) dut (
        .clk_i     (clk),
        .rst_ni    (rst_ni),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_rs     (wr_rs),
        .wr_data   (wr_data),
        .init_done (init_done),
        .lcd_on    (lcd_on),
        .lcd_en    (lcd_en),
        .lcd_rs    (lcd_rs),
        .lcd_rw    (lcd_rw),
        .lcd_data  (lcd_data)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Execution time the LCD needs after a byte, from the instruction rules.
    function automatic int wait_for(input logic rs, input logic [7:0] d);
        if (rs == 1'b0 && d >= 8'd1 && d <= 8'd3) return T_CLR;
        return T_CMD;
    endfunction

    task automatic release_reset();
        @(negedge clk);
        rst_ni  = 1'b1;
        rel_cyc = cyc + 1;
        for (int i = 0; i < 4; i++) begin
            pulse_q.push_back('{rs: 1'b0, data: init_seq[i],
                                tw: wait_for(1'b0, init_seq[i]), idx: i, acc: 0});
        end
    endtask

    // Hold wr_valid until n writes are accepted; called at a negedge.
    task automatic issue(input logic rs, input logic [7:0] d, input int n);
        int got = 0;
        int budget = 0;
        wr_valid = 1'b1;
        wr_rs    = rs;
        wr_data  = d;
        while (got < n && budget < 3000) begin
            if (wr_ready === 1'b1) begin
                chk("accept_after_init", {31'd0, init_done}, 32'd1);
                pulse_q.push_back('{rs: rs, data: d, tw: wait_for(rs, d), idx: -1, acc: cyc + 1});
                ready_q.push_back(cyc + 1 + T_SETUP + T_EN + T_HOLD + wait_for(rs, d) + 1);
                got++;
                @(negedge clk);
                budget++;
                chk("accept_taken", {31'd0, wr_ready}, 32'd0);
                if (got == n) wr_valid = 1'b0;
            end else begin
                @(negedge clk);
                budget++;
            end
        end
        if (got < n) begin
            chk("accept_timeout", got, n);
            wr_valid = 1'b0;
        end
    endtask

    // Monitor state
    pulse_t cur;
    logic   in_pulse = 1'b0, stable = 1'b1;
    logic   prev_en = 1'b0, prev_ready = 1'b0, prev_done = 1'b0;
    int     rise_cyc = 0, last_init_rise = 0, last_init_tw = 0, done_exp = -1;

    initial forever begin
        @(negedge clk);
        if (rst_ni !== 1'b1) begin
            in_pulse = 1'b0; prev_en = 1'b0; prev_ready = 1'b0; prev_done = 1'b0;
        end else begin
            if (lcd_en && !prev_en) begin
                chk("pulse_expected", {31'd0, pulse_q.size() != 0}, 32'd1);
                if (pulse_q.size() != 0) begin
                    cur = pulse_q.pop_front();
                    in_pulse = 1'b1; stable = 1'b1; rise_cyc = cyc;
                    chk("pulse_data", {22'd0, lcd_rw, lcd_rs, lcd_data}, {22'd0, 1'b0, cur.rs, cur.data});
                    if (cur.idx < 0)
                        chk("write_en_rise", cyc, cur.acc + T_SETUP);
                    else if (cur.idx == 0)
                        chk("init_first_rise", cyc, rel_cyc + T_PWRUP + T_SETUP);
                    else
                        chk("init_spacing", cyc - last_init_rise,
                            T_EN + T_HOLD + last_init_tw + 1 + T_SETUP);
                    if (cur.idx >= 0) begin
                        last_init_rise = cyc;
                        last_init_tw   = cur.tw;
                    end
                    if (cur.idx == 3) begin
                        done_exp = cyc + T_EN + T_HOLD + cur.tw;
                        ready_q.push_back(done_exp + 1);
                    end
                end
            end
            if (in_pulse && (lcd_rs !== cur.rs || lcd_data !== cur.data)) stable = 1'b0;
            if (!lcd_en && prev_en && in_pulse) begin
                chk("en_width", cyc - rise_cyc, T_EN);
                chk("bus_stable", {31'd0, stable}, 32'd1);
                in_pulse = 1'b0;
            end
            if (wr_ready && !prev_ready) begin
                chk("ready_expected", {31'd0, ready_q.size() != 0}, 32'd1);
                if (ready_q.size() != 0) chk("ready_return", cyc, ready_q.pop_front());
            end
            if (init_done && !prev_done) chk("init_done_time", cyc, done_exp);
            prev_en = lcd_en; prev_ready = wr_ready; prev_done = init_done;
        end
    end

    initial begin
        int found;
        logic       r_rs;
        logic [7:0] r_d;
        rst_ni = 1'b0; wr_valid = 1'b0; wr_rs = 1'b0; wr_data = 8'h00;
        repeat (2) @(negedge clk);
        chk("reset_values", {19'd0, wr_ready, init_done, lcd_on, lcd_en, lcd_rs, lcd_rw, lcd_data}, 32'd0);

        // Request pending before init completes: must wait for init_done.
        release_reset();
        @(negedge clk);
        chk("lcd_on_after_release", {31'd0, lcd_on}, 32'd1);
        issue(1'b1, 8'h5A, 1);

        issue(1'b1, 8'h41, 1);
        issue(1'b0, 8'h01, 1);
        issue(1'b1, 8'h01, 1);
        issue(1'b1, 8'h42, 3);

        for (int i = 0; i < 12; i++) begin
            r_rs = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) r_d = 8'($urandom_range(1, 3));
            else r_d = 8'($urandom_range(0, 255));
            issue(r_rs, r_d, 1);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        // Reset in the middle of an enable pulse.
        issue(1'b1, 8'h55, 1);
        found = 0;
        for (int i = 0; i < 50 && found == 0; i++) begin
            if (lcd_en === 1'b1) found = 1;
            else @(negedge clk);
        end
        chk("en_seen_before_reset", found, 1);
        #1 rst_ni = 1'b0;
        #1 chk("reset_async", {29'd0, lcd_en, wr_ready, init_done}, 32'd0);
        pulse_q.delete();
        ready_q.delete();
        repeat (2) @(negedge clk);
        chk("reset_values_mid", {19'd0, wr_ready, init_done, lcd_on, lcd_en, lcd_rs, lcd_rw, lcd_data}, 32'd0);
        release_reset();
        @(negedge clk);
        chk("lcd_on_after_rerelease", {31'd0, lcd_on}, 32'd1);
        issue(1'b0, 8'h02, 1);
        issue(1'b1, 8'h7A, 1);

        // Drain and confirm nothing expected is left outstanding.
        found = 0;
        for (int i = 0; i < 300 && found == 0; i++) begin
            @(negedge clk);
            if (wr_ready === 1'b1 && pulse_q.size() == 0) found = 1;
        end
        chk("drain_done", found, 1);
        chk("pulse_q_empty", pulse_q.size(), 0);
        chk("ready_q_empty", ready_q.size(), 0);
        repeat (30) @(negedge clk);
        chk("idle_no_pulse", {31'd0, lcd_en}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
